// File: rtl/run_delay_line.sv
// Delay line: samples in0 for a configured number of cycles and replays each
// sample on out0 a configured number of cycles later, using a circular buffer.
module run_delay_line #(
  parameter int DATA_W   = 32,
  parameter int DELAY_W  = 4,
  parameter int AMOUNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [DATA_W-1:0]   in0,
  input  logic [DELAY_W-1:0]  delay,
  input  logic [AMOUNT_W-1:0] amount,
  output logic [DATA_W-1:0]   out0,
  output logic                valid,
  output logic                running,
  output logic                done
);
  localparam int CW    = AMOUNT_W + 1;
  localparam int DEPTH = 2 ** DELAY_W;

  typedef enum logic [1:0] {IDLE, ACTIVE, FINISH} state_t;

  state_t              state_q, state_d;
  logic [DELAY_W-1:0]  d_q, d_d;
  logic [AMOUNT_W-1:0] n_q, n_d;
  logic [DELAY_W-1:0]  wptr_q, wptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                valid_q, valid_d;
  logic                running_q, done_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [CW-1:0]       end_cnt;
  logic [DELAY_W-1:0]  rptr;
  logic                in_win, wr_en;

  // The write pointer advances every ACTIVE cycle (even after the last write),
  // so wptr-d always addresses the sample taken d cycles earlier.
  assign end_cnt = {1'b0, n_q} + CW'(d_q);
  assign rptr    = wptr_q - d_q;
  assign in_win  = (cnt_q >= CW'(d_q)) && (cnt_q != end_cnt);
  assign wr_en   = (state_q == ACTIVE) && (cnt_q < {1'b0, n_q});

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    n_d     = n_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (run) begin
          d_d     = delay;
          n_d     = amount;
          wptr_d  = '0;
          cnt_d   = '0;
          state_d = (amount == '0) ? FINISH : ACTIVE;
        end
      end
      ACTIVE: begin
        wptr_d = wptr_q + 1'b1;
        if (in_win) begin
          valid_d = 1'b1;
          out_d   = (d_q == '0) ? in0 : mem[rptr];
        end
        if (cnt_q == end_cnt) state_d = FINISH;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      d_q       <= '0;
      n_q       <= '0;
      wptr_q    <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      d_q       <= d_d;
      n_q       <= n_d;
      wptr_q    <= wptr_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      running_q <= (state_d == ACTIVE);
      done_q    <= (state_d == FINISH);
    end
  end

  // Buffer contents carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q] <= in0;
  end

  assign out0    = out_q;
  assign valid   = valid_q;
  assign running = running_q;
  assign done    = done_q;
endmodule
